// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// =====================================================================
// Module  : regfile_write_arbiter
// Purpose : Round-robin sequencer for the shared register-file write
//           port, plus the PC load port ordered against R15 writes.
// Rev     : 1.0  initial release
// =====================================================================
module regfile_write_arbiter #(
  parameter int WIDTH = 32,
  parameter int SELW  = 4
) (
  input  logic             Clk,
  input  logic             RESET,
  input  logic             A_valid,
  input  logic [SELW-1:0]  A_sel,
  input  logic [WIDTH-1:0] A_data,
  output logic             A_ready,
  input  logic             B_valid,
  input  logic [SELW-1:0]  B_sel,
  input  logic [WIDTH-1:0] B_data,
  output logic             B_ready,
  input  logic             PC_valid,
  input  logic [WIDTH-1:0] PC_data,
  output logic             PC_ready,
  output logic [WIDTH-1:0] RF_in,
  output logic [SELW-1:0]  RF_wsel,
  output logic             RF_LOAD,
  output logic [WIDTH-1:0] RF_Pcin,
  output logic             RF_LOADPC,
  output logic             RF_IR_CU,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic            c_req_a  = 1'b0;
  localparam logic            c_req_b  = 1'b1;
  localparam logic [SELW-1:0] c_pc_sel = {SELW{1'b1}};

  state_t r_state;
  logic   r_last;
  logic   r_grant;

  logic   w_pick;
  logic   w_other_valid;
  logic   w_start;
  logic   w_next;
  logic   w_r15_commit;
  logic   w_pc_go;

  // Tie goes to whichever requester did not commit most recently.
  always_comb begin
    w_pick = c_req_a;
    if (A_valid && B_valid) begin
      w_pick = ~r_last;
    end else if (B_valid) begin
      w_pick = c_req_b;
    end
  end

  assign w_other_valid = (r_grant == c_req_a) ? B_valid : A_valid;

  // Leaving COMMIT only the other requester is eligible, so the one just
  // acknowledged cannot be re-granted on its still-high valid.
  assign w_start = ((r_state == IDLE) && (A_valid || B_valid)) ||
                   ((r_state == COMMIT) && w_other_valid);
  assign w_next  = (r_state == COMMIT) ? ~r_grant : w_pick;

  assign w_r15_commit = (r_state == SETUP) && (RF_wsel == c_pc_sel);
  assign w_pc_go      = PC_valid && !PC_ready && !w_r15_commit;

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      r_state   <= IDLE;
      r_last    <= c_req_b;
      r_grant   <= c_req_a;
      A_ready   <= 1'b0;
      B_ready   <= 1'b0;
      PC_ready  <= 1'b0;
      RF_in     <= '0;
      RF_wsel   <= '0;
      RF_LOAD   <= 1'b0;
      RF_Pcin   <= '0;
      RF_LOADPC <= 1'b0;
      RF_IR_CU  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      A_ready   <= 1'b0;
      B_ready   <= 1'b0;
      RF_LOAD   <= 1'b0;
      PC_ready  <= w_pc_go;
      RF_LOADPC <= w_pc_go;
      if (w_pc_go) begin
        RF_Pcin <= PC_data;
      end

      if (w_start) begin
        r_state  <= SETUP;
        r_grant  <= w_next;
        RF_in    <= (w_next == c_req_b) ? B_data : A_data;
        RF_wsel  <= (w_next == c_req_b) ? B_sel  : A_sel;
        RF_IR_CU <= 1'b0;
        busy     <= 1'b1;
      end else begin
        case (r_state)
          SETUP: begin
            r_state <= COMMIT;
            r_last  <= r_grant;
            A_ready <= (r_grant == c_req_a);
            B_ready <= (r_grant == c_req_b);
            // R15 is the PC: route the write to the PC port, pre-empting
            // any PC update that would land in the same cycle.
            if (w_r15_commit) begin
              RF_LOADPC <= 1'b1;
              RF_Pcin   <= RF_in;
            end else begin
              RF_LOAD <= 1'b1;
            end
          end
          COMMIT: begin
            r_state  <= IDLE;
            RF_IR_CU <= 1'b1;
            busy     <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// =====================================================================
// Module  : tb_regfile_write_arbiter
// Purpose : Self-checking bench for regfile_write_arbiter.
// Rev     : 1.0  initial release
// =====================================================================
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        RESET = 1'b0;
  logic        A_valid = 1'b0, B_valid = 1'b0, PC_valid = 1'b0;
  logic [3:0]  A_sel = '0, B_sel = '0;
  logic [31:0] A_data = '0, B_data = '0, PC_data = '0;
  logic        A_ready, B_ready, PC_ready;
  logic [31:0] RF_in, RF_Pcin;
  logic [3:0]  RF_wsel;
  logic        RF_LOAD, RF_LOADPC, RF_IR_CU, busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural register file fed by the arbiter's write controls.
  logic [31:0] rf [0:15] = '{default: 32'h0};
  logic [31:0] pc = 32'h0;

  regfile_write_arbiter #(.WIDTH(32), .SELW(4)) dut (
    .Clk(Clk), .RESET(RESET),
    .A_valid(A_valid), .A_sel(A_sel), .A_data(A_data), .A_ready(A_ready),
    .B_valid(B_valid), .B_sel(B_sel), .B_data(B_data), .B_ready(B_ready),
    .PC_valid(PC_valid), .PC_data(PC_data), .PC_ready(PC_ready),
    .RF_in(RF_in), .RF_wsel(RF_wsel), .RF_LOAD(RF_LOAD),
    .RF_Pcin(RF_Pcin), .RF_LOADPC(RF_LOADPC), .RF_IR_CU(RF_IR_CU), .busy(busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (RF_LOAD)   rf[RF_wsel] <= RF_in;
    if (RF_LOADPC) pc <= RF_Pcin;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    A_valid = 1'b0; B_valid = 1'b0; PC_valid = 1'b0;
    repeat (2) tick();
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    A_valid = 1'b1; A_sel = 4'd3; A_data = 32'h1;
    repeat (3) begin
      tick();
      n_checks++; if (A_ready !== 1'b0) $display("FAIL reset_a_ready: got %b want 0", A_ready); else n_pass++;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (RF_IR_CU !== 1'b1) $display("FAIL reset_ir_cu: got %b want 1", RF_IR_CU); else n_pass++;
    n_checks++; if ({RF_LOAD, RF_LOADPC, B_ready, PC_ready} !== 4'b0) $display("FAIL reset_strobes: got %b want 0000", {RF_LOAD, RF_LOADPC, B_ready, PC_ready}); else n_pass++;
    n_checks++; if ({RF_in, RF_Pcin, RF_wsel} !== 68'h0) $display("FAIL reset_data: got %h want 0", {RF_in, RF_Pcin, RF_wsel}); else n_pass++;
    A_valid = 1'b0;
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    A_valid = 1'b1; A_sel = 4'd3; A_data = 32'h1;
    tick();
    n_checks++; if ({busy, RF_IR_CU, RF_LOAD, A_ready} !== 4'b1000) $display("FAIL single_setup_ctl: got %b want 1000", {busy, RF_IR_CU, RF_LOAD, A_ready}); else n_pass++;
    n_checks++; if ({RF_wsel, RF_in} !== {4'd3, 32'h1}) $display("FAIL single_setup_data: got %h want 300000001", {RF_wsel, RF_in}); else n_pass++;
    tick();
    n_checks++; if ({RF_LOAD, A_ready, B_ready, RF_LOADPC} !== 4'b1100) $display("FAIL single_commit: got %b want 1100", {RF_LOAD, A_ready, B_ready, RF_LOADPC}); else n_pass++;
    tick();
    A_valid = 1'b0;
    n_checks++; if ({RF_LOAD, A_ready, busy, RF_IR_CU} !== 4'b0001) $display("FAIL single_after: got %b want 0001", {RF_LOAD, A_ready, busy, RF_IR_CU}); else n_pass++;
    n_checks++; if (rf[3] !== 32'h1) $display("FAIL single_r3: got %h want 1", rf[3]); else n_pass++;
  endtask

  task automatic test_tie();
    do_reset();
    A_valid = 1'b1; A_sel = 4'd1; A_data = 32'hA;
    B_valid = 1'b1; B_sel = 4'd2; B_data = 32'hB;
    tick();
    n_checks++; if ({busy, RF_wsel} !== {1'b1, 4'd1}) $display("FAIL tie_setup_a: got %h want 11", {busy, RF_wsel}); else n_pass++;
    tick();
    n_checks++; if ({A_ready, B_ready, RF_LOAD} !== 3'b101) $display("FAIL tie_commit_a: got %b want 101", {A_ready, B_ready, RF_LOAD}); else n_pass++;
    tick();
    A_valid = 1'b0;
    n_checks++; if ({busy, RF_LOAD, RF_wsel, RF_in} !== {1'b1, 1'b0, 4'd2, 32'hB}) $display("FAIL tie_setup_b: got %h want %h", {busy, RF_LOAD, RF_wsel, RF_in}, {1'b1, 1'b0, 4'd2, 32'hB}); else n_pass++;
    tick();
    n_checks++; if ({A_ready, B_ready, RF_LOAD} !== 3'b011) $display("FAIL tie_commit_b: got %b want 011", {A_ready, B_ready, RF_LOAD}); else n_pass++;
    tick();
    B_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL tie_idle: got %b want 0", busy); else n_pass++;
    n_checks++; if ({rf[1], rf[2]} !== {32'hA, 32'hB}) $display("FAIL tie_regs: got %h want 0000000a0000000b", {rf[1], rf[2]}); else n_pass++;
  endtask

  task automatic test_fairness();
    int  k = 0;
    bit  a_ack = 0, b_ack = 0;
    bit  who;
    do_reset();
    A_valid = 1'b1; A_sel = 4'd4; A_data = 32'h100;
    B_valid = 1'b1; B_sel = 4'd6; B_data = 32'h200;
    for (int cyc = 0; cyc < 60 && k < 8; cyc++) begin
      tick();
      if (a_ack) begin A_data = A_data + 1; a_ack = 0; end
      if (b_ack) begin B_data = B_data + 1; b_ack = 0; end
      if (A_ready || B_ready) begin
        who = B_ready;
        n_checks++; if ({A_ready, B_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL fair_order_%0d: got %b want %b", k, {A_ready, B_ready}, (k % 2 == 0) ? 2'b10 : 2'b01); else n_pass++;
        n_checks++; if (RF_in !== (who ? B_data : A_data)) $display("FAIL fair_data_%0d: got %h want %h", k, RF_in, who ? B_data : A_data); else n_pass++;
        if (who) b_ack = 1; else a_ack = 1;
        k++;
      end
    end
    n_checks++; if (k !== 8) $display("FAIL fair_count: got %0d want 8", k); else n_pass++;
    tick();
    A_valid = 1'b0; B_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_r15();
    do_reset();
    B_valid = 1'b1; B_sel = 4'd15; B_data = 32'h40;
    tick();
    PC_valid = 1'b1; PC_data = 32'h80;
    tick();
    n_checks++; if ({RF_LOADPC, RF_LOAD, B_ready, PC_ready} !== 4'b1010) $display("FAIL r15_commit_ctl: got %b want 1010", {RF_LOADPC, RF_LOAD, B_ready, PC_ready}); else n_pass++;
    n_checks++; if (RF_Pcin !== 32'h40) $display("FAIL r15_commit_pcin: got %h want 40", RF_Pcin); else n_pass++;
    tick();
    B_valid = 1'b0;
    n_checks++; if ({PC_ready, RF_LOADPC, RF_Pcin} !== {2'b11, 32'h80}) $display("FAIL r15_pc_follow: got %h want 300000080", {PC_ready, RF_LOADPC, RF_Pcin}); else n_pass++;
    n_checks++; if (pc !== 32'h40) $display("FAIL r15_pc_mid: got %h want 40", pc); else n_pass++;
    tick();
    PC_valid = 1'b0;
    n_checks++; if (PC_ready !== 1'b0) $display("FAIL r15_pc_single: got %b want 0", PC_ready); else n_pass++;
    n_checks++; if (pc !== 32'h80) $display("FAIL r15_pc_final: got %h want 80", pc); else n_pass++;
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    A_valid = 1'b1; A_sel = 4'd5; A_data = 32'h55;
    repeat (3) tick();
    A_data = 32'h99;
    tick();
    n_checks++; if ({busy, RF_wsel, RF_in} !== {1'b1, 4'd5, 32'h99}) $display("FAIL midrst_setup: got %h want 1599", {busy, RF_wsel, RF_in}); else n_pass++;
    RESET = 1'b0;
    #1;
    A_valid = 1'b0;
    n_checks++; if ({busy, A_ready, RF_LOAD} !== 3'b000) $display("FAIL midrst_abort: got %b want 000", {busy, A_ready, RF_LOAD}); else n_pass++;
    tick();
    n_checks++; if (A_ready !== 1'b0) $display("FAIL midrst_no_ready: got %b want 0", A_ready); else n_pass++;
    RESET = 1'b1;
    tick();
    n_checks++; if ({busy, RF_IR_CU} !== 2'b01) $display("FAIL midrst_idle: got %b want 01", {busy, RF_IR_CU}); else n_pass++;
    n_checks++; if (rf[5] !== 32'h55) $display("FAIL midrst_r5: got %h want 55", rf[5]); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0]  qa_sel [10];
    logic [3:0]  qb_sel [10];
    logic [31:0] qa_d   [10];
    logic [31:0] qb_d   [10];
    logic [31:0] qp     [6];
    logic [31:0] exp_rf [16];
    bit          wr     [16];
    int ai = 0, bi = 0, pi = 0;
    int agap = 0, bgap = 0, pgap = 0, pwait = 0;
    bit aack = 0, back = 0, pack = 0;
    for (int i = 0; i < 16; i++) begin exp_rf[i] = 32'h0; wr[i] = 0; end
    for (int i = 0; i < 10; i++) begin
      qa_sel[i] = 4'($urandom_range(0, 6));  qa_d[i] = $urandom;
      qb_sel[i] = 4'($urandom_range(7, 14)); qb_d[i] = $urandom;
    end
    for (int i = 0; i < 6; i++) qp[i] = $urandom;
    // Reference: A and B target disjoint registers, so the final contents
    // are simply the last value each queue wrote to every register.
    for (int i = 0; i < 10; i++) begin
      exp_rf[qa_sel[i]] = qa_d[i]; wr[qa_sel[i]] = 1;
      exp_rf[qb_sel[i]] = qb_d[i]; wr[qb_sel[i]] = 1;
    end
    do_reset();
    for (int cyc = 0; cyc < 600 && !(ai == 10 && bi == 10 && pi == 6); cyc++) begin
      tick();
      if (PC_valid && !pack) pwait++;
      if (aack) begin ai++; A_valid = 1'b0; agap = $urandom_range(0, 2); aack = 0; end
      if (back) begin bi++; B_valid = 1'b0; bgap = $urandom_range(0, 2); back = 0; end
      if (pack) begin pi++; PC_valid = 1'b0; pgap = $urandom_range(0, 3); pack = 0; end
      if (!A_valid && ai < 10) begin
        if (agap == 0) begin A_valid = 1'b1; A_sel = qa_sel[ai]; A_data = qa_d[ai]; end
        else agap--;
      end
      if (!B_valid && bi < 10) begin
        if (bgap == 0) begin B_valid = 1'b1; B_sel = qb_sel[bi]; B_data = qb_d[bi]; end
        else bgap--;
      end
      if (!PC_valid && pi < 6) begin
        if (pgap == 0) begin PC_valid = 1'b1; PC_data = qp[pi]; pwait = 0; end
        else pgap--;
      end
      if (A_ready) begin
        n_checks++; if (!(ai < 10 && {RF_LOAD, RF_wsel, RF_in} === {1'b1, qa_sel[ai], qa_d[ai]})) $display("FAIL rand_a_write_%0d: got %h want %h", ai, {RF_LOAD, RF_wsel, RF_in}, {1'b1, qa_sel[ai % 10], qa_d[ai % 10]}); else n_pass++;
        aack = 1;
      end
      if (B_ready) begin
        n_checks++; if (!(bi < 10 && {RF_LOAD, RF_wsel, RF_in} === {1'b1, qb_sel[bi], qb_d[bi]})) $display("FAIL rand_b_write_%0d: got %h want %h", bi, {RF_LOAD, RF_wsel, RF_in}, {1'b1, qb_sel[bi % 10], qb_d[bi % 10]}); else n_pass++;
        back = 1;
      end
      if (PC_ready) begin
        n_checks++; if (!(pi < 6 && pwait == 1 && RF_LOADPC === 1'b1 && RF_Pcin === qp[pi])) $display("FAIL rand_pc_%0d: got wait=%0d pcin=%h want wait=1 pcin=%h", pi, pwait, RF_Pcin, qp[pi % 6]); else n_pass++;
        pack = 1;
      end
    end
    n_checks++; if ({ai, bi, pi} !== {32'd10, 32'd10, 32'd6}) $display("FAIL rand_timeout: got a=%0d b=%0d pc=%0d want 10 10 6", ai, bi, pi); else n_pass++;
    A_valid = 1'b0; B_valid = 1'b0; PC_valid = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 15; i++) begin
      if (wr[i]) begin
        n_checks++; if (rf[i] !== exp_rf[i]) $display("FAIL rand_reg_%0d: got %h want %h", i, rf[i], exp_rf[i]); else n_pass++;
      end
    end
    n_checks++; if (pc !== qp[5]) $display("FAIL rand_pc_final: got %h want %h", pc, qp[5]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_r15();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
